// File: rtl/mac_accum.sv
// mac_accum: signed multiply-accumulate of COUNT operand pairs with a valid/ready result port.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous abort of the partial sum, pending result and pipeline
//   en, stall       operand pair valid, global pipeline freeze
//   a, b            signed operands (BITS wide)
//   in_ready        a beat can be accepted (IDLE or ACCUM)
//   out_valid       result valid, held until out_ready
//   out_ready       consumer takes result
//   result          signed dot product (ACC_BITS wide, modulo 2^ACC_BITS)
//   busy            state is not IDLE
module mac_accum #(
    parameter int BITS     = 8,
    parameter int COUNT    = 8,
    parameter int ACC_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                stall,
    input  logic [BITS-1:0]     a,
    input  logic [BITS-1:0]     b,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] result,
    output logic                busy
);
    localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic signed [ACC_BITS-1:0] acc_q, acc_d, result_q, result_d, prod_x;
    logic signed [2*BITS-1:0]   prod_q, prod_d;
    logic                       pv_q, pv_d, ov_q, ov_d, accept, last;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign busy      = state_q != IDLE;
    assign out_valid = ov_q;
    assign result    = result_q;
    assign accept    = en & ~stall & in_ready;
    assign prod_x    = ACC_BITS'(prod_q);
    // cnt is 0 in IDLE, so a single-product set finishes on its first beat
    assign last      = (COUNT == 1) || (cnt_q == CW'(COUNT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        pv_d     = pv_q;
        result_d = result_q;
        ov_d     = ov_q;
        if (accept) begin
            prod_d = (2*BITS)'($signed(a)) * (2*BITS)'($signed(b));
            pv_d   = 1'b1;
        end else if (!stall) begin
            pv_d = 1'b0;
        end
        if (pv_q && !stall)
            acc_d = acc_q + prod_x;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = last ? FLUSH : ACCUM;
                    cnt_d   = last ? '0 : cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                // the final product is still in stage 1; fold it straight into the result
                if (!stall) begin
                    result_d = acc_q + prod_x;
                    ov_d     = 1'b1;
                    acc_d    = '0;
                    pv_d     = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // the output handshake ignores stall
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            prod_d   = '0;
            pv_d     = 1'b0;
            result_d = '0;
            ov_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            pv_q     <= 1'b0;
            result_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            pv_q     <= pv_d;
            result_q <= result_d;
            ov_q     <= ov_d;
        end
    end
endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: table-driven and scoreboard bench for mac_accum (BITS=8, COUNT=8, ACC_BITS=24).
module tb_mac_accum;
    logic              clk, rst, clr, en, stall, out_ready;
    logic signed [7:0] a, b;
    logic              in_ready, out_valid, busy;
    logic [23:0]       result;

    mac_accum #(.BITS(8), .COUNT(8), .ACC_BITS(24)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .stall(stall), .a(a), .b(b),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    typedef struct {
        int a0;
        int da;
        int b;
        int exp;
    } vec_t;

    vec_t              vt[7];
    logic signed [7:0] va[8], vb[8];
    logic [23:0]       exp_q[$];
    logic [23:0]       e;
    int                n_cmp = 0, n_err = 0, cyc = 0;
    int                tf, tl, tr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] model(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(va[i]) * int'(vb[i]);
        return 24'(s);
    endfunction

    task automatic wait_valid(output int t);
        int k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: out_valid got 0 required 1");
        end
        t = cyc;
    endtask

    task automatic run_set(input int n, input int st_at, input int st_len,
                           output int t_first, output int t_last);
        int k = 0;
        t_first = 0;
        t_last  = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        check("in_ready_start", 32'(in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i == st_at) begin
                en    = 1'b1;
                stall = 1'b1;
                a     = 8'sd0;
                b     = 8'sd0;
                repeat (st_len) tick();
                stall = 1'b0;
            end
            en = 1'b1;
            a  = va[i];
            b  = vb[i];
            tick();
            if (i == 0) t_first = cyc;
            t_last = cyc;
        end
        en = 1'b0;
        a  = 8'sd0;
        b  = 8'sd0;
    endtask

    task automatic load(input int a0, input int da, input int bv);
        for (int i = 0; i < 8; i++) begin
            va[i] = 8'(a0 + i * da);
            vb[i] = 8'(bv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got result %0h required no result", result);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", 32'(result), 32'(e));
            end
        end
    end

    initial begin
        vt[0] = '{1, 1, 2, 72};
        vt[1] = '{-3, 0, 5, -120};
        vt[2] = '{-128, 0, -128, 131072};
        vt[3] = '{127, 0, 127, 129032};
        vt[4] = '{-128, 0, 127, -130048};
        vt[5] = '{-4, 1, -1, 4};
        vt[6] = '{0, 0, 99, 0};
        rst = 1'b1; clr = 1'b0; en = 1'b0; stall = 1'b0; out_ready = 1'b1;
        a = 8'sd0; b = 8'sd0;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            load(vt[v].a0, vt[v].da, vt[v].b);
            run_set(8, -1, 0, tf, tl);
            exp_q.push_back(24'(vt[v].exp));
            check("flush_busy", 32'(busy), 32'd1);
            check("flush_in_ready", 32'(in_ready), 32'd0);
            wait_valid(tr);
            check("latency", 32'(tr - tl), 32'd1);
            check("span", 32'(tr - tf), 32'd8);
            check("hold_busy", 32'(busy), 32'd1);
            tick();
            check("hs_out_valid", 32'(out_valid), 32'd0);
            check("hs_in_ready", 32'(in_ready), 32'd1);
            check("hs_busy", 32'(busy), 32'd0);
        end

        load(1, 1, 2);
        run_set(8, 4, 3, tf, tl);
        exp_q.push_back(24'd72);
        wait_valid(tr);
        check("stall_mid_span", 32'(tr - tf), 32'd11);
        tick();

        load(1, 0, 1);
        run_set(8, -1, 0, tf, tl);
        exp_q.push_back(24'd8);
        stall = 1'b1;
        tick();
        tick();
        check("flush_stall_hold", 32'(out_valid), 32'd0);
        stall = 1'b0;
        wait_valid(tr);
        check("flush_stall_latency", 32'(tr - tl), 32'd3);
        tick();

        out_ready = 1'b0;
        load(1, 1, 2);
        run_set(8, -1, 0, tf, tl);
        exp_q.push_back(24'd72);
        wait_valid(tr);
        stall = 1'b1;
        out_ready = 1'b1;
        tick();
        check("hold_stall_hs", 32'(out_valid), 32'd0);
        check("hold_stall_ready", 32'(in_ready), 32'd1);
        stall = 1'b0;

        out_ready = 1'b0;
        run_set(8, -1, 0, tf, tl);
        exp_q.push_back(24'd72);
        wait_valid(tr);
        for (int i = 0; i < 5; i++) begin
            en = 1'b1;
            a  = 8'sd9;
            b  = 8'sd9;
            tick();
            check("bp_result", 32'(result), 32'd72);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        load(1, 0, 1);
        run_set(8, -1, 0, tf, tl);
        exp_q.push_back(24'd8);
        wait_valid(tr);
        tick();

        load(7, 0, 7);
        run_set(5, -1, 0, tf, tl);
        clr = 1'b1;
        en  = 1'b1;
        a   = 8'sd7;
        b   = 8'sd7;
        tick();
        clr = 1'b0;
        en  = 1'b0;
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_result", 32'(result), 32'd0);
        load(2, 0, 3);
        run_set(8, -1, 0, tf, tl);
        exp_q.push_back(24'd48);
        wait_valid(tr);
        tick();

        load(3, 0, 3);
        run_set(8, -1, 0, tf, tl);
        check("arst_pre_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        load(1, 1, 2);
        run_set(8, -1, 0, tf, tl);
        exp_q.push_back(24'd72);
        wait_valid(tr);
        tick();

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                va[i] = 8'($urandom_range(0, 255));
                vb[i] = 8'($urandom_range(0, 255));
            end
            run_set(8, (r % 2 == 0) ? int'($urandom_range(0, 7)) : -1, 2, tf, tl);
            exp_q.push_back(model(8));
            wait_valid(tr);
            tick();
        end

        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_accum.md
# mac_accum

- Multiply-accumulate stage directly downstream of the operand delay buffers in the minilab4 datapath.
- Consumes one signed operand pair per enabled, unstalled cycle and sums `COUNT` products into a wide accumulator.
- Presents the finished dot product on a valid/ready output handshake.
- Throttles upstream through `in_ready` while a result is being finalised or is waiting to be taken.

## Interface
- `BITS`, 8: width of each signed two's-complement operand (matches the delay-buffer width).
- `COUNT`, 8: number of products per result; legal range is ≥1.
- `ACC_BITS`, 24: accumulator and result width; must satisfy ≥ 2*BITS + clog2(COUNT).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous abort: discards the partial sum, any pending result and the pipeline.
- `en`  in  1  operand pair valid, driven by the same enable that advances the delay buffers.
- `stall`  in  1  global stall; the input and accumulate pipeline freeze while it is high.
- `a`  in  BITS  signed operand A, taken from the delay-buffer output.
- `b`  in  BITS  signed operand B, taken from the delay-buffer output.
- `in_ready`  out  1  high when a beat can be accepted (state IDLE or ACCUM).
- `out_valid`  out  1  `result` is valid; it stays high until the handshake completes.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  ACC_BITS  signed sum of `COUNT` products.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Beat acceptance:** `accept = en & ~stall & in_ready`. When `en` is high while `in_ready` is low, the beat is ignored and nothing changes.
- **Stage 1 (multiply):** on `accept`, `prod_r <= $signed(a)*$signed(b)` (2*BITS wide) and `p_valid <= 1`. Otherwise, when not stalled, `p_valid <= 0`.
- **Stage 2 (accumulate):** when `p_valid & ~stall`, `acc <= acc + sext(prod_r)`.
  - Arithmetic is modulo 2^ACC_BITS, with no saturation.
- **Beat counter:** `cnt` counts accepted beats from 0 to COUNT-1.
- **FSM states:** IDLE, ACCUM, FLUSH, HOLD.
  - **IDLE:** `acc` = 0 and `cnt` = 0. On `accept`, go to ACCUM, or go straight to FLUSH if COUNT==1.
  - **ACCUM:** on `accept` with `cnt==COUNT-1`, go to FLUSH, `cnt <= 0` and `in_ready` drops. Any other `accept` does `cnt++`.
  - **FLUSH:** on the first edge where `~stall`:
    - `result <= acc + sext(prod_r)`, `out_valid <= 1`, `acc <= 0`, `p_valid <= 0`;
    - go to HOLD.
  - **HOLD:** `result` is held stable and `out_valid` stays 1. On `out_valid & out_ready`, `out_valid <= 0` and go to IDLE.
    - `stall` does not affect the HOLD handshake.
- **`stall` high:**
  - `prod_r`, `p_valid`, `acc`, `cnt` and the state all hold their values.
  - Exception: the HOLD→IDLE handshake still proceeds.
  - A delay buffer outputs 0 under stall; that 0 is never accumulated.
- **`clr` (synchronous, highest priority below `rst`):**
  - `acc`, `cnt`, `p_valid`, `prod_r` and `result` go to 0, `out_valid` goes to 0, and the state goes to IDLE.
  - `clr` overrides a same-cycle accept and a same-cycle handshake.
- **`rst` (asynchronous, any state):** all registers clear immediately, without waiting for a clock edge.
  - Outputs go to their reset values: `out_valid`=0, `result`=0, `in_ready`=1, `busy`=0, state IDLE.

## Timing
- **Latency:** the last beat is accepted at edge T. With no stall, `out_valid` rises and `result` is valid after edge T+1.
  - Each stalled cycle from T onward adds one cycle of latency.
- **`in_ready`:**
  - Low from after edge T until after the handshake edge.
  - Back high in the cycle following the handshake, so the next set can begin one cycle after the result is taken.
- **Throughput:** with `out_ready` held high, a result is produced every COUNT+2 cycles.
- **Registered outputs:** `in_ready`, `busy` and `out_valid` are registered or purely state-decoded, with no combinational path from `en`, `a` or `b`.
  - `out_ready` reaches only the next-state logic, never any output combinationally.

## Test plan
- **Basic dot product:** assert `rst`, release it, then 8 consecutive beats with a=1..8, b=2 → `out_valid`=1 one cycle after the 8th accept edge, `result`=72, `busy`=1 until the handshake.
- **Signed arithmetic:**
  - 8 beats of a=-3, b=5 → `result`=0xFFFF88 (-120).
  - Then 8 beats of a=-128, b=-128 → `result`=131072.
- **Stall mid-set:** raise `stall` for 3 cycles after beat 4 while holding `en`=1 → `result`=72 for the basic-case data, and `out_valid` arrives exactly 3 cycles later than in the unstalled case.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises while pulsing `en` with a=9, b=9 →
  - `result` stays stable and `in_ready`=0;
  - the `en` pulses are ignored;
  - after the handshake, a set of 8×(a=1, b=1) gives `result`=8.
- **Abort:** pulse `clr` after 5 beats → the next cycle shows `in_ready`=1, `busy`=0, `out_valid`=0; the next full set of 8×(a=2, b=3) gives `result`=48.
- **Asynchronous reset:** assert `rst` between clock edges while in FLUSH → `out_valid`=0, `result`=0, `in_ready`=1 immediately; the following set gives a correct sum with no residue.
